// File: rtl/sao_edge_filter.sv
// sao_edge_filter: streaming sample-adaptive-offset stage for 8-bit luma in raster order.
// Modes: pass-through, horizontal edge offset (EO 0 deg), band offset.
// Build option: define SAO_BAND_OFFSET_EN to include band offset; otherwise mode 2 is pass-through.
module sao_edge_filter #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int OFFSET_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_pixel,
    input  logic                  in_sof,
    input  logic                  in_eol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_pixel,
    output logic                  out_sof,
    output logic                  out_eol,
    input  logic [1:0]            cfg_mode,
    input  logic [4*OFFSET_W-1:0] cfg_offsets,
    input  logic [4:0]            cfg_band_pos,
    output logic                  frame_done,
    output logic                  err
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, FIRST, RUN, FLUSH} state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              a_reg, a_next;          // left neighbour of c
    logic [7:0]              c_reg, c_next;          // pixel waiting for its right neighbour
    logic                    c_valid_reg, c_valid_next;
    logic [COL_W-1:0]        col_reg, col_next;      // column of c
    logic [ROW_W-1:0]        row_reg, row_next;
    logic [1:0]              mode_reg, mode_next;
    logic [4*OFFSET_W-1:0]   offsets_reg, offsets_next;
    logic                    err_reg, err_next;
    logic                    out_valid_reg, out_valid_next;
    logic [7:0]              out_pixel_reg, out_pixel_next;
    logic                    out_sof_reg, out_sof_next;
    logic                    out_eol_reg, out_eol_next;
    logic                    out_last_reg, out_last_next;  // output is the last pixel of the frame

`ifdef SAO_BAND_OFFSET_EN
    logic [4:0]              band_pos_reg, band_pos_next;
    logic [4:0]              band_k;
`else
    logic                    unused_band_pos;
    assign unused_band_pos = ^cfg_band_pos;
`endif

    logic                    slot_free;
    logic                    accept;
    logic [COL_W-1:0]        x;          // column of the pixel being accepted
    logic                    emit, emit_eol, emit_last, emit_edge;
    logic [2:0]              cat;
    logic [9:0]              sel_off;
    logic [7:0]              filt_pixel;
    logic [9:0]              off_ext [4];

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = !reset && (state_reg != FLUSH) && slot_free;
    assign accept    = in_valid && in_ready;
    assign x         = c_valid_reg ? col_reg + COL_W'(1) : '0;
    assign emit_edge = (state_reg == FLUSH) || (col_reg == '0);

    // Sign-extend each frame offset to the 10-bit arithmetic width.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_off
            assign off_ext[gi] = {{(10-OFFSET_W){offsets_reg[gi*OFFSET_W+OFFSET_W-1]}},
                                  offsets_reg[gi*OFFSET_W +: OFFSET_W]};
        end
    endgenerate

    function automatic logic [2:0] eo_cat(input logic [7:0] a, input logic [7:0] c, input logic [7:0] b);
        if (c < a && c < b) return 3'd1;
        if ((c < a && c == b) || (c == a && c < b)) return 3'd2;
        if ((c > a && c == b) || (c == a && c > b)) return 3'd3;
        if (c > a && c > b) return 3'd4;
        return 3'd0;
    endfunction

    // Negative sums clip to 0, sums above 255 clip to 255.
    function automatic logic [7:0] clip_add(input logic [7:0] pix, input logic [9:0] off);
        logic [9:0] sum;
        sum = {2'b00, pix} + off;
        if (sum[9]) return 8'd0;
        if (sum[8]) return 8'hFF;
        return sum[7:0];
    endfunction

    // Offset selection for the held pixel c, right neighbour is the incoming pixel.
    always_comb begin
        cat     = 3'd0;
        sel_off = '0;
        if (mode_reg == 2'd1 && !emit_edge) begin
            cat = eo_cat(a_reg, c_reg, in_pixel);
            if (cat != 3'd0) sel_off = off_ext[2'(cat - 3'd1)];
        end
`ifdef SAO_BAND_OFFSET_EN
        band_k = c_reg[7:3] - band_pos_reg;
        if (mode_reg == 2'd2 && band_k < 5'd4) sel_off = off_ext[band_k[1:0]];
`endif
        filt_pixel = clip_add(c_reg, sel_off);
    end

    // Next-state, window, counters and output slot.
    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        c_next         = c_reg;
        c_valid_next   = c_valid_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        mode_next      = mode_reg;
        offsets_next   = offsets_reg;
        err_next       = err_reg;
        out_valid_next = out_valid_reg;
        out_pixel_next = out_pixel_reg;
        out_sof_next   = out_sof_reg;
        out_eol_next   = out_eol_reg;
        out_last_next  = out_last_reg;
        emit           = 1'b0;
        emit_eol       = 1'b0;
        emit_last      = 1'b0;
`ifdef SAO_BAND_OFFSET_EN
        band_pos_next  = band_pos_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (accept && !in_sof) err_next = 1'b1;
            end
            FIRST, RUN: begin
                if (accept && !in_sof) begin
                    emit         = c_valid_reg;
                    a_next       = c_reg;
                    c_next       = in_pixel;
                    c_valid_next = 1'b1;
                    col_next     = x;
                    if (in_eol != (x == COL_W'(WIDTH-1))) err_next = 1'b1;
                    if (in_eol || x == COL_W'(WIDTH-1)) state_next = FLUSH;
                    else state_next = c_valid_reg ? RUN : FIRST;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit         = 1'b1;
                    emit_eol     = 1'b1;
                    emit_last    = (row_reg == ROW_W'(HEIGHT-1));
                    c_valid_next = 1'b0;
                    if (row_reg == ROW_W'(HEIGHT-1)) begin
                        state_next = IDLE;
                    end else begin
                        row_next   = row_reg + ROW_W'(1);
                        state_next = FIRST;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A start of frame always restarts; outside IDLE it is a framing error.
        if (accept && in_sof) begin
            if (state_reg != IDLE) err_next = 1'b1;
            mode_next    = cfg_mode;
            offsets_next = cfg_offsets;
`ifdef SAO_BAND_OFFSET_EN
            band_pos_next = cfg_band_pos;
`endif
            c_next       = in_pixel;
            c_valid_next = 1'b1;
            col_next     = '0;
            row_next     = '0;
            if (in_eol) begin
                err_next   = 1'b1;
                state_next = FLUSH;
            end else begin
                state_next = FIRST;
            end
        end
        if (slot_free) begin
            out_valid_next = emit;
            if (emit) begin
                out_pixel_next = filt_pixel;
                out_sof_next   = (row_reg == '0) && (col_reg == '0);
                out_eol_next   = emit_eol;
                out_last_next  = emit_last;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            c_reg         <= '0;
            c_valid_reg   <= 1'b0;
            col_reg       <= '0;
            row_reg       <= '0;
            mode_reg      <= '0;
            offsets_reg   <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
            out_sof_reg   <= 1'b0;
            out_eol_reg   <= 1'b0;
            out_last_reg  <= 1'b0;
`ifdef SAO_BAND_OFFSET_EN
            band_pos_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            c_reg         <= c_next;
            c_valid_reg   <= c_valid_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            mode_reg      <= mode_next;
            offsets_reg   <= offsets_next;
            err_reg       <= err_next;
            out_valid_reg <= out_valid_next;
            out_pixel_reg <= out_pixel_next;
            out_sof_reg   <= out_sof_next;
            out_eol_reg   <= out_eol_next;
            out_last_reg  <= out_last_next;
`ifdef SAO_BAND_OFFSET_EN
            band_pos_reg  <= band_pos_next;
`endif
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_pixel  = out_pixel_reg;
    assign out_sof    = out_sof_reg;
    assign out_eol    = out_eol_reg;
    assign err        = err_reg;
    assign frame_done = out_valid_reg && out_ready && out_last_reg;

endmodule

// File: tb/tb_sao_edge_filter.sv
// tb_sao_edge_filter: random and directed frames against a behavioural SAO model.
module tb_sao_edge_filter;
    localparam int W = 8;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_sof = 1'b0, in_eol = 1'b0;
    logic [7:0]  in_pixel = '0, out_pixel;
    logic        out_valid, out_ready = 1'b1, out_sof, out_eol, frame_done, err;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_offsets = '0;
    logic [4:0]  cfg_band_pos = '0;

    always #5 clk = ~clk;

    sao_edge_filter #(.WIDTH(W), .HEIGHT(H), .OFFSET_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sof(out_sof), .out_eol(out_eol),
        .cfg_mode(cfg_mode), .cfg_offsets(cfg_offsets), .cfg_band_pos(cfg_band_pos),
        .frame_done(frame_done), .err(err)
    );

    typedef struct { int px; bit sof; bit eol; } beat_t;
    typedef struct { int px; bit sof; bit eol; bit fd; } obeat_t;

    beat_t  bq[$];
    obeat_t eq[$];
    int     got_px[$];
    int     frame_px [H][W];
    int     n_vec = 0, n_err = 0;
    int     f_mode, f_band, f_offs[4];
    bit     exp_err = 1'b0;
    int     ready_low;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected output pixel straight from the offset rules.
    function automatic int ref_pixel(int c, int a, int b, bit edge_pos);
        int o, k, v;
        o = 0;
        if (f_mode == 1 && !edge_pos) begin
            if (c < a && c < b) o = f_offs[0];
            else if ((c < a && c == b) || (c == a && c < b)) o = f_offs[1];
            else if ((c > a && c == b) || (c == a && c > b)) o = f_offs[2];
            else if (c > a && c > b) o = f_offs[3];
        end
`ifdef SAO_BAND_OFFSET_EN
        if (f_mode == 2) begin
            k = ((c / 8) - f_band + 32) % 32;
            if (k < 4) o = f_offs[k];
        end
`else
        k = 0;
`endif
        v = c + o;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic set_cfg(input int mode, input int o0, input int o1, input int o2, input int o3, input int band);
        f_mode = mode; f_band = band;
        f_offs[0] = o0; f_offs[1] = o1; f_offs[2] = o2; f_offs[3] = o3;
        cfg_mode = 2'(mode);
        cfg_band_pos = 5'(band);
        for (int i = 0; i < 4; i++) cfg_offsets[i*4 +: 4] = 4'(f_offs[i]);
    endtask

    // Append a clean frame from frame_px to the input beats and expected outputs.
    task automatic build_frame();
        int a, b;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                bq.push_back('{frame_px[r][c], (r == 0 && c == 0), (c == W-1)});
                a = (c > 0) ? frame_px[r][c-1] : 0;
                b = (c < W-1) ? frame_px[r][c+1] : 0;
                eq.push_back('{ref_pixel(frame_px[r][c], a, b, (c == 0 || c == W-1)),
                               (r == 0 && c == 0), (c == W-1), (r == H-1 && c == W-1)});
            end
    endtask

    function automatic int rand_px();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 255));
        return 100 + int'($urandom_range(0, 2));
    endfunction

    task automatic rand_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame_px[r][c] = rand_px();
    endtask

    // Drive bq, collect outputs; the first `skip` outputs are not compared.
    task automatic run(input string name, input bit bp, input int skip);
        int idx, got, cyc, total, last_sof, extra;
        bit held;
        logic [9:0] held_val;
        obeat_t e;
        idx = 0; got = 0; cyc = 0; extra = 0; last_sof = -1; held = 1'b0; held_val = '0;
        ready_low = 0;
        total = skip + eq.size();
        for (int i = 0; i < bq.size(); i++) if (bq[i].sof) last_sof = i;
        got_px.delete();
        while ((idx < bq.size() || got < total) && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx > last_sof) begin
                cfg_mode = 2'($urandom); cfg_offsets = 16'($urandom); cfg_band_pos = 5'($urandom);
            end
            if (idx < bq.size() && (!bp || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1; in_pixel = 8'(bq[idx].px); in_sof = bq[idx].sof; in_eol = bq[idx].eol;
            end else begin
                in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_pixel = 8'($urandom);
            end
            @(negedge clk);
            if (held) begin
                check_val({name, " stall_hold"}, {out_valid, out_sof, out_eol, out_pixel}, {1'b1, held_val});
                held = 1'b0;
            end
            if (out_valid && !out_ready) begin
                held = 1'b1; held_val = {out_sof, out_eol, out_pixel};
            end
            if (out_valid && out_ready) begin
                if (got >= skip) begin
                    if (got - skip < eq.size()) begin
                        e = eq[got - skip];
                        check_val({name, " beat"}, {frame_done, out_sof, out_eol, out_pixel},
                                  {e.fd, e.sof, e.eol, 8'(e.px)});
                        got_px.push_back(int'(out_pixel));
                    end else begin
                        check_val({name, " extra_beat"}, got + 1, total);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            if (!in_ready) ready_low++;
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
        check_val({name, " beats_out"}, got, total);
        check_val({name, " beats_in"}, idx, bq.size());
        repeat (3) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check_val({name, " no_extra"}, extra, 0);
        check_val({name, " err"}, err, exp_err);
        $display("%s: %0d beats in, %0d beats out, %0d cycles", name, idx, got, cyc);
        bq.delete(); eq.delete();
    endtask

    task automatic reset_dut();
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst in_ready", in_ready, 0);
        check_val("rst out_valid", out_valid, 0);
        check_val("rst out_pixel", out_pixel, 0);
        check_val("rst out_sof", out_sof, 0);
        check_val("rst out_eol", out_eol, 0);
        check_val("rst frame_done", frame_done, 0);
        check_val("rst err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("post_rst out_valid", out_valid, 0);
        end
        $display("reset applied");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_eo[W] = '{10, 8, 9, 11, 19, 19, 16, 15};
        int band_row[W] = '{250, 5, 20, 100, 8, 16, 24, 255};
        int exp_band[4];
        reset_dut();

        // Partial frame, then reset: the held pixel must never appear.
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame_px[r][c] = r * W + c;
        set_cfg(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) bq.push_back('{frame_px[0][c], (c == 0), 1'b0});
        run("partial", 1'b0, 3);
        reset_dut();

        // Pass-through ramp, one in_ready gap per line.
        set_cfg(0, 0, 0, 0, 0, 0);
        build_frame();
        run("pass", 1'b0, 0);
        check_val("pass ready_low", ready_low, H);

        // EO on a repeated line.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                frame_px[r][c] = 10;
                if (c == 1) frame_px[r][c] = 5;
                if (c == 4 || c == 5) frame_px[r][c] = 20;
                if (c >= 6) frame_px[r][c] = 15;
            end
        set_cfg(1, 3, 1, -1, -3, 0);
        build_frame();
        run("eo", 1'b0, 0);
        for (int c = 0; c < W; c++) check_val("eo literal", got_px[c], exp_eo[c]);

        // Clipping at both ends.
        rand_frame();
        for (int c = 0; c < W; c++) begin
            frame_px[0][c] = (c == 1) ? 254 : 255;
            frame_px[1][c] = (c == 1) ? 3 : 0;
        end
        set_cfg(1, 7, 0, 0, -8, 0);
        build_frame();
        run("clip", 1'b0, 0);
        check_val("clip high", got_px[1], 255);
        check_val("clip low", got_px[W+1], 0);

        // Band offset with band index wrap.
        rand_frame();
        for (int c = 0; c < W; c++) frame_px[0][c] = band_row[c];
        set_cfg(2, 2, 2, 2, 2, 31);
        build_frame();
        run("band", 1'b0, 0);
`ifdef SAO_BAND_OFFSET_EN
        exp_band = '{252, 7, 22, 100};
`else
        exp_band = '{250, 5, 20, 100};
`endif
        for (int c = 0; c < 4; c++) check_val("band literal", got_px[c], exp_band[c]);

        // Random frames under random backpressure and input gaps.
        for (int f = 0; f < 8; f++) begin
            rand_frame();
            set_cfg((f < 3) ? 1 : int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                    int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                    int'($urandom_range(0, 31)));
            build_frame();
            run($sformatf("rand%0d", f), 1'b1, 0);
        end

        // Early eol, then a stray sof that restarts into a clean frame.
        rand_frame();
        set_cfg(1, 2, 1, -1, -2, 0);
        bq.push_back('{11, 1'b1, 1'b0});
        bq.push_back('{22, 1'b0, 1'b0});
        bq.push_back('{33, 1'b0, 1'b1});
        bq.push_back('{44, 1'b0, 1'b0});
        bq.push_back('{55, 1'b0, 1'b0});
        build_frame();
        exp_err = 1'b1;
        run("framing", 1'b1, 4);

        rand_frame();
        set_cfg(1, -3, 4, 5, -6, 0);
        build_frame();
        run("sticky", 1'b1, 0);

        exp_err = 1'b0;
        reset_dut();
        rand_frame();
        set_cfg(1, 1, 2, -2, -1, 0);
        build_frame();
        run("after_reset", 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
